alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_funct_dec.sv | 35 +++
 rtl/alu_seq.sv | 129 ++++++++++++
 tb/tb_alu_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: ALU operation codes, MIPS R-type funct codes,
// FSM state encoding and a small next-state helper.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Illegal commands skip the ALU and respond straight from DONE.
  function automatic state_e accept_target(input logic illegal);
    return illegal ? S_DONE : S_EXEC;
  endfunction

endpackage

// File: rtl/alu_funct_dec.sv
// Combinational MIPS R-type funct decoder: ALU operation, illegal flag and
// whether the op is a signed (overflow-trapping) ADD/SUB.
module alu_funct_dec
  import alu_seq_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic       signed_op
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    alu_op    = ALU_AND;
    illegal   = 1'b0;
    signed_op = 1'b0;
    case (funct)
      FUNCT_AND:  alu_op = ALU_AND;
      FUNCT_OR:   alu_op = ALU_OR;
      FUNCT_ADD: begin
        alu_op    = ALU_ADD;
        signed_op = 1'b1;
      end
      FUNCT_ADDU: alu_op = ALU_ADD;
      FUNCT_SUB: begin
        alu_op    = ALU_SUB;
        signed_op = 1'b1;
      end
      FUNCT_SUBU: alu_op = ALU_SUB;
      FUNCT_SLT:  alu_op = ALU_SLT;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequencer that issues one R-type command at a time to an external
// combinational ALU and returns its result through a valid/ready response.
// Optional feature: define ALU_SEQ_OVF_TRAP_EN to trap signed ADD/SUB overflow.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [5:0]            cmd_funct,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_ALUop,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Overflow,
  input  logic                  alu_CarryOut,
  input  logic                  alu_Zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_carry,
  output logic                  rsp_ovf,
  output logic                  rsp_illegal,
  output logic                  rsp_trap
);

`ifdef ALU_SEQ_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e     state, state_next;
  logic [2:0] dec_op;
  logic       dec_illegal;
  logic       dec_signed;
  logic       signed_q;
  logic       accept;
  logic       trap_hit;

  alu_funct_dec u_dec (
    .funct     (cmd_funct),
    .alu_op    (dec_op),
    .illegal   (dec_illegal),
    .signed_op (dec_signed)
  );

  assign accept   = cmd_valid && cmd_ready;
  // With the trap disabled this folds to 0, leaving rsp_trap stuck at its reset value.
  assign trap_hit = TRAP_EN && signed_q && alu_Overflow;

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = accept_target(dec_illegal);
      S_EXEC: state_next = S_DONE;
      S_DONE: begin
        if (rsp_ready) state_next = cmd_valid ? accept_target(dec_illegal) : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_DONE: begin
        cmd_ready = rsp_ready;
        rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU drive registers hold the last legal command; response registers
  // change only on capture, so they stay stable while a response is stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: these are plain registers, not a memory, so all of them are reset.
      alu_A       <= '0;
      alu_B       <= '0;
      alu_ALUop   <= ALU_AND;
      signed_q    <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_carry   <= 1'b0;
      rsp_ovf     <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_trap    <= 1'b0;
    end else begin
      if (accept && !dec_illegal) begin
        alu_A     <= cmd_a;
        alu_B     <= cmd_b;
        alu_ALUop <= dec_op;
        signed_q  <= dec_signed;
      end
      if (accept && dec_illegal) begin
        rsp_result  <= '0;
        rsp_zero    <= 1'b0;
        rsp_carry   <= 1'b0;
        rsp_ovf     <= 1'b0;
        rsp_illegal <= 1'b1;
        rsp_trap    <= 1'b0;
      end else if (state == S_EXEC) begin
        rsp_result  <= trap_hit ? '0 : alu_Result;
        rsp_zero    <= alu_Zero;
        rsp_carry   <= alu_CarryOut;
        rsp_ovf     <= alu_Overflow;
        rsp_illegal <= 1'b0;
        rsp_trap    <= trap_hit;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: the bench plays the external ALU, a driver
// issues directed and random commands, and a monitor scores every response.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         cmd_valid, cmd_ready;
  logic [5:0]   cmd_funct;
  logic [W-1:0] cmd_a, cmd_b;
  logic [W-1:0] alu_A, alu_B, alu_Result;
  logic [2:0]   alu_ALUop;
  logic         alu_Overflow, alu_CarryOut, alu_Zero;
  logic         rsp_valid, rsp_ready = 1'b1;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_carry, rsp_ovf, rsp_illegal, rsp_trap;

  typedef struct {
    logic [W-1:0] result;
    logic         zero, carry, ovf, illegal, trap;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    int           latency;
    int           issue_edge;
  } exp_t;

  exp_t         exp_q[$];
  int           n_pass = 0;
  int           n_total = 0;
  int           edges = 0;
  int           bp_mode = 0;  // 0: always ready, 1: never ready, 2: random
  logic [W-1:0] last_a = '0, last_b = '0;
  logic [2:0]   last_op = '0;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  always @(negedge clk) begin
    case (bp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'b0;
      default: rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  alu_seq #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_funct    (cmd_funct),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_ALUop    (alu_ALUop),
    .alu_Result   (alu_Result),
    .alu_Overflow (alu_Overflow),
    .alu_CarryOut (alu_CarryOut),
    .alu_Zero     (alu_Zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_carry    (rsp_carry),
    .rsp_ovf      (rsp_ovf),
    .rsp_illegal  (rsp_illegal),
    .rsp_trap     (rsp_trap)
  );

  // External ALU: carry on subtract is the unsigned borrow.
  always_comb begin
    alu_Result   = '0;
    alu_CarryOut = 1'b0;
    alu_Overflow = 1'b0;
    case (alu_ALUop)
      3'b000: alu_Result = alu_A & alu_B;
      3'b001: alu_Result = alu_A | alu_B;
      3'b010: begin
        {alu_CarryOut, alu_Result} = {1'b0, alu_A} + {1'b0, alu_B};
        alu_Overflow = (alu_A[W-1] == alu_B[W-1]) && (alu_Result[W-1] != alu_A[W-1]);
      end
      3'b110: begin
        {alu_CarryOut, alu_Result} = {1'b0, alu_A} - {1'b0, alu_B};
        alu_Overflow = (alu_A[W-1] != alu_B[W-1]) && (alu_Result[W-1] != alu_A[W-1]);
      end
      3'b111: alu_Result = {{(W-1){1'b0}}, ($signed(alu_A) < $signed(alu_B))};
      default: ;
    endcase
    alu_Zero = (alu_Result == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: expected response from funct and operands in integer arithmetic.
  function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    e = '{result: '0, zero: 0, carry: 0, ovf: 0, illegal: 0, trap: 0,
          a: a, b: b, op: '0, latency: 2, issue_edge: 0};
    case (f)
      6'h24: begin e.result = a & b; e.op = 3'b000; end
      6'h25: begin e.result = a | b; e.op = 3'b001; end
      6'h20, 6'h21: begin
        s = sa + sb;
        e.result = a + b;
        e.carry  = (longint'(a) + longint'(b)) > longint'(32'hFFFF_FFFF);
        e.ovf    = (s != longint'($signed(e.result)));
        e.op     = 3'b010;
      end
      6'h22, 6'h23: begin
        s = sa - sb;
        e.result = a - b;
        e.carry  = (a < b);
        e.ovf    = (s != longint'($signed(e.result)));
        e.op     = 3'b110;
      end
      6'h2A: begin e.result = (sa < sb) ? 1 : 0; e.op = 3'b111; end
      default: begin
        e.illegal = 1'b1;
        e.latency = 1;
        e.a = last_a; e.b = last_b; e.op = last_op;
      end
    endcase
    if (!e.illegal) e.zero = (e.result == '0);
`ifdef ALU_SEQ_OVF_TRAP_EN
    if ((f == 6'h20 || f == 6'h22) && e.ovf) begin
      e.trap   = 1'b1;
      e.result = '0;
    end
`endif
    return e;
  endfunction

  // Called at negedge+1; returns at negedge+1 after the accepting edge.
  task automatic send(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   waited = 0;
    cmd_funct = f; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready) begin
      @(negedge clk); #1;
      if (++waited > 1000) begin
        $display("FAIL cmd_accept_timeout: cmd_ready stuck at %b", cmd_ready);
        $fatal(1, "command never accepted");
      end
    end
    e = model(f, a, b);
    e.issue_edge = edges;
    exp_q.push_back(e);
    if (!e.illegal) begin last_a = a; last_b = b; last_op = e.op; end
    @(negedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_flags"}, {rsp_result, rsp_zero, rsp_carry, rsp_ovf, rsp_illegal, rsp_trap}, 0);
    check({tag, "_alu"}, {alu_A, alu_B, alu_ALUop}, 0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] rand_funct();
    logic [5:0] legal[7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
    if ($urandom_range(0, 7) == 0) return 6'($urandom);
    return legal[$urandom_range(0, 6)];
  endfunction

  // Monitor: scores each response on its first valid cycle, then checks that it holds.
  initial begin
    exp_t         e;
    logic [W+4:0] cur, snap;
    bit           pending = 0;
    snap = '0;
    forever begin
      @(negedge clk); #2;
      if (!resetn) pending = 0;
      else if (rsp_valid) begin
        cur = {rsp_result, rsp_zero, rsp_carry, rsp_ovf, rsp_illegal, rsp_trap};
        if (!pending) begin
          if (exp_q.size() == 0) check("unexpected_rsp", rsp_valid, 0);
          else begin
            e = exp_q[0];
            check("latency", edges - e.issue_edge, e.latency);
            check("rsp_result", rsp_result, e.result);
            check("rsp_flags", {rsp_zero, rsp_carry, rsp_ovf, rsp_illegal, rsp_trap},
                  {e.zero, e.carry, e.ovf, e.illegal, e.trap});
            check("alu_drive", {alu_A, alu_B, alu_ALUop}, {e.a, e.b, e.op});
          end
          pending = 1;
          snap = cur;
        end else check("rsp_stable", cur, snap);
        check("cmd_ready_in_done", cmd_ready, rsp_ready);
        if (rsp_ready) begin
          pending = 0;
          if (exp_q.size() != 0) exp_q.delete(0);
        end
      end
    end
  end

  initial begin
    int budget;
    cmd_valid = 1'b0; cmd_funct = '0; cmd_a = '0; cmd_b = '0;
    #1 resetn = 1'b0;
    #2 check_zeroed("por");
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    check("cmd_ready_after_rst", cmd_ready, 1);

    send(6'h20, 32'h7FFF_FFFF, 32'h0000_0001);  // ADD overflow
    send(6'h23, 32'd5, 32'd5);                  // SUBU to zero
    send(6'h2A, 32'hFFFF_FFFF, 32'h0000_0001);  // SLT -1 < 1
    send(6'h2A, 32'h0000_0001, 32'hFFFF_FFFF);  // SLT 1 < -1
    send(6'h00, 32'h1234_5678, 32'h9ABC_DEF0);  // illegal
    send(6'h22, 32'h8000_0000, 32'h0000_0001);  // SUB overflow
    send(6'h25, 32'hF0F0_0000, 32'h0000_0F0F);
    idle(3);

    bp_mode = 1;
    send(6'h21, 32'hFFFF_FFFF, 32'h0000_0001);  // ADDU carry, no overflow
    idle(7);
    bp_mode = 0;
    send(6'h24, 32'hFF00_FF00, 32'h0F0F_0F0F);  // accepted in the handshake cycle
    send(6'h3F, 32'h1, 32'h2);                  // illegal back-to-back
    idle(4);

    bp_mode = 2;
    for (int i = 0; i < 200; i++) begin
      send(rand_funct(), rand_operand(), rand_operand());
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    bp_mode = 0;
    idle(6);

    send(6'h22, 32'd10, 32'd3);                 // now in EXEC
    check("in_exec_no_valid", rsp_valid, 0);
    resetn = 1'b0;
    exp_q.delete();
    last_a = '0; last_b = '0; last_op = '0;
    #1 check_zeroed("rst_exec");
    @(negedge clk); #1 resetn = 1'b1;
    check("cmd_ready_after_rst2", cmd_ready, 1);
    idle(4);
    check("no_rsp_after_rst", rsp_valid, 0);
    send(6'h2A, 32'h0000_0000, 32'h8000_0000);  // illegal-free recovery
    send(6'h01, 32'h5, 32'h6);                  // illegal after reset: alu_* keep recovery op

    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin @(negedge clk); #1; budget++; end
    check("drain_empty", exp_q.size(), 0);
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
